// File: rtl/nlms_weight_update_pkg.sv
// Shared defaults, FSM encoding and coefficient saturation limits for the NLMS
// coefficient-update engine and the filter datapath that reads its weights.
package nlms_pkg;
  localparam int DEF_N_TAPS   = 32;
  localparam int DEF_XW       = 14;
  localparam int DEF_WW       = 32;
  localparam int DEF_MU_SHIFT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic signed [DEF_WW-1:0] WMAX = {1'b0, {(DEF_WW-1){1'b1}}};
  localparam logic signed [DEF_WW-1:0] WMIN = {1'b1, {(DEF_WW-1){1'b0}}};
endpackage

// File: rtl/nlms_weight_update_if.sv
// Update request / preload / weight bus between the coefficient updater and its users.
interface nlms_weight_update_if import nlms_pkg::*; #(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int XW     = DEF_XW,
  parameter int WW     = DEF_WW
);
  localparam int AW = $clog2(N_TAPS);

  logic                   upd_start;
  logic [XW-1:0]          e_in;
  logic [N_TAPS*XW-1:0]   x_flat;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WW-1:0]          wr_data;
  logic                   upd_busy;
  logic                   upd_done;
  logic [N_TAPS*WW-1:0]   weight_flat;

  modport master (
    output upd_start, e_in, x_flat, wr_en, wr_addr, wr_data,
    input  upd_busy, upd_done, weight_flat
  );
  modport slave (
    input  upd_start, e_in, x_flat, wr_en, wr_addr, wr_data,
    output upd_busy, upd_done, weight_flat
  );
endinterface

// File: rtl/nlms_weight_update_mac_sat.sv
// Registered signed multiply, then arithmetic-shift and saturating accumulate onto
// the weight the caller selects with idx_o.
module nlms_mac_sat #(
  parameter int XW       = 14,
  parameter int WW       = 32,
  parameter int MU_SHIFT = 12,
  parameter int IW       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_i,
  input  logic signed [XW-1:0] a_i,
  input  logic signed [XW-1:0] b_i,
  input  logic [IW-1:0]        idx_i,
  input  logic signed [WW-1:0] w_i,
  output logic                 vld_o,
  output logic [IW-1:0]        idx_o,
  output logic signed [WW-1:0] w_o
);
  localparam logic signed [WW-1:0] WMAX_L = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] WMIN_L = {1'b1, {(WW-1){1'b0}}};

  logic signed [2*XW-1:0] p_q;
  logic [IW-1:0]          p_idx_q;
  logic                   p_vld_q;
  logic signed [2*XW-1:0] p_sh;
  logic signed [WW:0]     w_ext, p_ext, sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      p_idx_q <= '0;
      p_vld_q <= 1'b0;
    end else begin
      p_vld_q <= vld_i;
      if (vld_i) begin
        p_q     <= a_i * b_i;
        p_idx_q <= idx_i;
      end
    end
  end

  // One guard bit above WW makes overflow visible as a sign mismatch.
  assign p_sh  = p_q >>> MU_SHIFT;
  assign w_ext = (WW+1)'(w_i);
  assign p_ext = (WW+1)'(p_sh);
  assign sum   = w_ext + p_ext;

  always_comb begin
    w_o = sum[WW-1:0];
    if (sum[WW] != sum[WW-1]) w_o = sum[WW] ? WMIN_L : WMAX_L;
  end

  assign vld_o = p_vld_q;
  assign idx_o = p_idx_q;
endmodule

// File: rtl/nlms_weight_update.sv
// LMS coefficient updater: one tap per cycle through a shared MAC, weights held
// in a register file and exported as a flat registered bus.
module nlms_weight_update import nlms_pkg::*; #(
  parameter int N_TAPS   = DEF_N_TAPS,
  parameter int XW       = DEF_XW,
  parameter int WW       = DEF_WW,
  parameter int MU_SHIFT = DEF_MU_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  nlms_weight_update_if.slave  bus
);
  localparam int IW = $clog2(N_TAPS);

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q;
  logic signed [XW-1:0]      e_snap_q;
  logic [N_TAPS-1:0][XW-1:0] x_snap_q;
  logic [N_TAPS-1:0][WW-1:0] w_q;
  logic                      p_vld;
  logic [IW-1:0]             p_idx;
  logic signed [WW-1:0]      w_new;
  logic                      start_ok, last;

  assign start_ok = (state_q == IDLE) && bus.upd_start;
  assign last     = (idx_q == IW'(N_TAPS-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.upd_start) state_d = RUN;
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Preload writes only land in IDLE, so they never collide with MAC writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      e_snap_q <= '0;
      x_snap_q <= '0;
      w_q      <= '0;
    end else begin
      if (start_ok) begin
        e_snap_q <= bus.e_in;
        x_snap_q <= bus.x_flat;
        idx_q    <= '0;
      end else if (state_q == RUN) begin
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == IDLE && bus.wr_en && int'(bus.wr_addr) < N_TAPS)
        w_q[bus.wr_addr] <= bus.wr_data;
      if (p_vld)
        w_q[p_idx] <= w_new;
    end
  end

  nlms_mac_sat #(.XW(XW), .WW(WW), .MU_SHIFT(MU_SHIFT), .IW(IW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .vld_i (state_q == RUN),
    .a_i   (e_snap_q),
    .b_i   (x_snap_q[idx_q]),
    .idx_i (idx_q),
    .w_i   (w_q[p_idx]),
    .vld_o (p_vld),
    .idx_o (p_idx),
    .w_o   (w_new)
  );

  assign bus.upd_busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.upd_done    = (state_q == DONE);
  assign bus.weight_flat = w_q;
endmodule
